ex_mem_stage_reg: RTL and testbench
===================================

Name: ex_mem_stage_reg

Overview:
- Parametrised EX/MEM pipeline register for the 32-bit MIPS pipeline.
- Successor to the fixed-width EX/MEM latch: it adds the destination-register field, a valid bit, stall (hold) and flush (bubble insert), and synchronous active-low reset.
- Also provides combinational forwarding-hit and load-use flags, computed from its registered state, for the EX-stage forwarding unit.
- Sits between the ALU stage and the data-memory stage.

Parameters:
- DATA_W, 32, width of ALU_Result and RT_data paths.
- REG_ADDR_W, 5, width of register-file address fields (dest, rs, rt).
- CNT_W, 16, width of performance counters (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- stall  in  1  hold all registered state this cycle.
- flush  in  1  replace the next register contents with a bubble.
- valid_in  in  1  EX-stage instruction valid.
- RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in  in  1 each  control bits from EX.
- ALU_Result_in  in  DATA_W  ALU result.
- RT_data_in  in  DATA_W  store data.
- dest_in  in  REG_ADDR_W  destination register selected by the ID/EX RegDst mux.
- rs_in, rt_in  in  REG_ADDR_W  source registers of the instruction currently in EX.
- valid_out  out  1  registered valid.
- RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out  out  1 each  registered control bits.
- ALU_Result_out, RT_data_out  out  DATA_W  registered data.
- dest_out  out  REG_ADDR_W  registered destination register.
- fwd_rs_hit, fwd_rt_hit  out  1 each  EX/MEM forwarding match for rs/rt.
- load_use_hazard  out  1  MEM-stage load targets rs or rt of the EX instruction.

Behaviour:
- All register updates occur on the rising edge of clk. Priority per edge: reset > flush > stall > load.
- Reset (rst_n=0 at edge): every registered output = 0 (valid_out, the four control bits, ALU_Result_out, RT_data_out, dest_out). Asynchronous changes of rst_n have no effect until the next edge.
- Flush (rst_n=1, flush=1): valid_out and the four control outputs <- 0; ALU_Result_out, RT_data_out, dest_out <- 0. Flush overrides a simultaneous stall.
- Stall (flush=0, stall=1): all registered outputs hold their current values. Inputs are ignored.
- Load (flush=0, stall=0): all fields capture inputs with 1-cycle latency.
  - valid_out <- valid_in.
  - Control outputs <- control inputs AND valid_in, so an invalid instruction never produces a write.
  - Data fields and dest_out are captured unconditionally.
- Forwarding flags (combinational, from registered state):
  - Let live = valid_out & RegWrite_out & (dest_out != 0).
  - fwd_rs_hit = live & (dest_out == rs_in).
  - fwd_rt_hit = live & (dest_out == rt_in).
  - Register $0 never forwards.
- load_use_hazard = valid_out & MemRead_out & (dest_out != 0) & (dest_out == rs_in | dest_out == rt_in).
- Flag behaviour across stall, flush and reset:
  - During a stall, the flags continue to reflect the held contents.
  - After a flush or reset, all three flags are 0.
- No arithmetic on data paths; widths pass straight through.

Optional Feature:
- Macro: EX_MEM_PERF_CNT_EN.
- Defined: adds two output ports, bubble_cnt and stall_cnt, each CNT_W wide.
  - bubble_cnt increments on each edge where flush=1, or where a load occurs with valid_in=0.
  - stall_cnt increments on each edge where stall=1 and flush=0.
  - Both counters saturate at all-ones (no wrap) and are cleared to 0 by rst_n=0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with all inputs at 1 / 0xFFFFFFFF -> every output reads 0 after the first edge; all flags = 0.
- Load: valid_in=1, RegWrite_in=1, ALU_Result_in=0x00000009, RT_data_in=0x00000003, dest_in=8 -> after 1 edge the outputs show exactly those values and valid_out=1. With rs_in=8, fwd_rs_hit=1; with rt_in=9, fwd_rt_hit=0.
- Invalid gating and $0: valid_in=0 with all control inputs at 1 -> control outputs are 0 and valid_out=0. Separately, load dest_in=0 with RegWrite_in=1, rs_in=0 -> fwd_rs_hit=0.
- Stall: load ALU_Result 0x11, then stall=1 for 3 edges while ALU_Result_in=0x22 -> output stays 0x11. After stall drops, 0x22 appears after 1 edge.
- Flush beats stall: with valid contents held, assert stall=1 and flush=1 together -> next edge gives valid_out=0, control outputs 0, dest_out=0, all flags 0.
- Load-use and counters: load MemRead_in=1, dest_in=5, then rt_in=5 -> load_use_hazard=1. With EX_MEM_PERF_CNT_EN and CNT_W=2, apply 5 stall edges -> stall_cnt saturates at 3.

Source files
------------

// File: rtl/ex_mem_stage_reg_if.sv
// ex_mem_stage_reg_if: EX/MEM pipeline register bus.
// The EX-side inputs are stall, flush, valid_in, the four control bits,
// ALU_Result_in, RT_data_in, dest_in, rs_in and rt_in.
// The MEM-side outputs are valid_out, the four control bits, ALU_Result_out,
// RT_data_out and dest_out.
// The forwarding outputs are fwd_rs_hit, fwd_rt_hit and load_use_hazard.
// master drives the EX-side inputs; slave is the register itself.
interface ex_mem_stage_reg_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  stall, flush, valid_in;
    logic                  RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in;
    logic [DATA_W-1:0]     ALU_Result_in, RT_data_in;
    logic [REG_ADDR_W-1:0] dest_in, rs_in, rt_in;
    logic                  valid_out;
    logic                  RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out;
    logic [DATA_W-1:0]     ALU_Result_out, RT_data_out;
    logic [REG_ADDR_W-1:0] dest_out;
    logic                  fwd_rs_hit, fwd_rt_hit, load_use_hazard;

    modport master (
        output stall, flush, valid_in,
        output RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in,
        output ALU_Result_in, RT_data_in, dest_in, rs_in, rt_in,
        input  valid_out, RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out,
        input  ALU_Result_out, RT_data_out, dest_out,
        input  fwd_rs_hit, fwd_rt_hit, load_use_hazard
    );

    modport slave (
        input  stall, flush, valid_in,
        input  RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in,
        input  ALU_Result_in, RT_data_in, dest_in, rs_in, rt_in,
        output valid_out, RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out,
        output ALU_Result_out, RT_data_out, dest_out,
        output fwd_rs_hit, fwd_rt_hit, load_use_hazard
    );
endinterface

// File: rtl/ex_mem_stage_reg.sv
// ex_mem_stage_reg: EX/MEM pipeline register with stall, flush and forwarding flags.
// The plain ports are clk (rising-edge clock) and rst_n (synchronous
// active-low reset).
// The bus port is ex_mem_stage_reg_if.slave, which carries the EX-side
// inputs, the registered MEM-side outputs and the forwarding and load-use
// flags.
// The EX_MEM_PERF_CNT_EN macro adds two saturating counters, bubble_cnt and
// stall_cnt, each CNT_W wide.
module ex_mem_stage_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    ex_mem_stage_reg_if.slave bus
`ifdef EX_MEM_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);
    if (DATA_W < 1 || REG_ADDR_W < 1 || CNT_W < 1) begin : g_param_chk
        $error("ex_mem_stage_reg: all widths must be at least 1");
    end

    logic                  valid_q;
    logic [3:0]            ctrl_q;
    logic [DATA_W-1:0]     alu_q, rtd_q;
    logic [REG_ADDR_W-1:0] dest_q;
    logic [3:0]            ctrl_in;
    logic                  live;

    // The control bits are packed as {RegWrite, MemtoReg, MemRead, MemWrite}.
    assign ctrl_in = {bus.RegWrite_in, bus.MemtoReg_in, bus.MemRead_in, bus.MemWrite_in};

    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            alu_q   <= '0;
            rtd_q   <= '0;
            dest_q  <= '0;
        end else if (!bus.stall) begin
            valid_q <= bus.valid_in;
            ctrl_q  <= bus.valid_in ? ctrl_in : 4'b0;
            alu_q   <= bus.ALU_Result_in;
            rtd_q   <= bus.RT_data_in;
            dest_q  <= bus.dest_in;
        end
    end

    assign bus.valid_out      = valid_q;
    assign bus.RegWrite_out   = ctrl_q[3];
    assign bus.MemtoReg_out   = ctrl_q[2];
    assign bus.MemRead_out    = ctrl_q[1];
    assign bus.MemWrite_out   = ctrl_q[0];
    assign bus.ALU_Result_out = alu_q;
    assign bus.RT_data_out    = rtd_q;
    assign bus.dest_out       = dest_q;

    // Register $0 is hardwired to zero, so it is never forwarded.
    assign live               = valid_q & ctrl_q[3] & (|dest_q);
    assign bus.fwd_rs_hit     = live & (dest_q == bus.rs_in);
    assign bus.fwd_rt_hit     = live & (dest_q == bus.rt_in);
    assign bus.load_use_hazard = valid_q & ctrl_q[1] & (|dest_q) &
                                 ((dest_q == bus.rs_in) | (dest_q == bus.rt_in));

`ifdef EX_MEM_PERF_CNT_EN
    // A bubble is either a flush or a load of an invalid instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if ((bus.flush || (!bus.stall && !bus.valid_in)) && !(&bubble_cnt))
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            if (bus.stall && !bus.flush && !(&stall_cnt))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// tb_ex_mem_stage_reg: table, corner-case and randomized checks of ex_mem_stage_reg.
module tb_ex_mem_stage_reg;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ex_mem_stage_reg_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

`ifdef EX_MEM_PERF_CNT_EN
    logic [CW-1:0] bubble_cnt, stall_cnt;
    ex_mem_stage_reg #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt));
`else
    ex_mem_stage_reg #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    typedef struct {
        logic        rst_n, stall, flush, v;
        logic [3:0]  ctrl;
        logic [31:0] alu, rtd;
        logic [4:0]  dest, rs, rt;
        logic        e_v;
        logic [3:0]  e_ctrl;
        logic [31:0] e_alu, e_rtd;
        logic [4:0]  e_dest;
        logic        e_rs, e_rt, e_lu;
    } vec_t;

    typedef struct {
        logic        v;
        logic [3:0]  ctrl;
        logic [31:0] alu, rtd;
        logic [4:0]  dest;
    } state_t;

    state_t m;
    int     m_bub, m_stl;
    int     checks = 0, failures = 0;
    vec_t   tbl[$];

    function automatic vec_t mk(logic r, logic s, logic f, logic v, logic [3:0] c,
                                logic [31:0] a, logic [31:0] d, logic [4:0] ds,
                                logic [4:0] rs, logic [4:0] rt, logic ev, logic [3:0] ec,
                                logic [31:0] ea, logic [31:0] ed, logic [4:0] eds,
                                logic ers, logic ert, logic elu);
        vec_t x;
        x.rst_n = r; x.stall = s; x.flush = f; x.v = v; x.ctrl = c;
        x.alu = a; x.rtd = d; x.dest = ds; x.rs = rs; x.rt = rt;
        x.e_v = ev; x.e_ctrl = ec; x.e_alu = ea; x.e_rtd = ed; x.e_dest = eds;
        x.e_rs = ers; x.e_rt = ert; x.e_lu = elu;
        return x;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic drv(logic r, logic s, logic f, logic v, logic [3:0] c, logic [31:0] a,
                       logic [31:0] d, logic [4:0] ds, logic [4:0] rs, logic [4:0] rt);
        rst_n = r; bus.stall = s; bus.flush = f; bus.valid_in = v;
        {bus.RegWrite_in, bus.MemtoReg_in, bus.MemRead_in, bus.MemWrite_in} = c;
        bus.ALU_Result_in = a; bus.RT_data_in = d; bus.dest_in = ds;
        bus.rs_in = rs; bus.rt_in = rt;
    endtask

    // Advances one edge and applies the register rules to the reference state.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            m = '{default: '0};
            m_bub = 0;
            m_stl = 0;
        end else begin
            if (bus.flush || (!bus.stall && !bus.valid_in)) m_bub = (m_bub < CMAX) ? m_bub + 1 : CMAX;
            if (bus.stall && !bus.flush) m_stl = (m_stl < CMAX) ? m_stl + 1 : CMAX;
            if (bus.flush) m = '{default: '0};
            else if (!bus.stall) begin
                m.v    = bus.valid_in;
                m.ctrl = bus.valid_in ? {bus.RegWrite_in, bus.MemtoReg_in, bus.MemRead_in, bus.MemWrite_in} : 4'b0;
                m.alu  = bus.ALU_Result_in;
                m.rtd  = bus.RT_data_in;
                m.dest = bus.dest_in;
            end
        end
        #1;
    endtask

    task automatic chk_cnt();
`ifdef EX_MEM_PERF_CNT_EN
        chk("bubble_cnt", 32'(bubble_cnt), m_bub);
        chk("stall_cnt", 32'(stall_cnt), m_stl);
`endif
    endtask

    task automatic chk_model(string tag);
        bit live, hit_rs, hit_rt;
        live   = m.v && m.ctrl[3] && m.dest != 0;
        hit_rs = m.dest == bus.rs_in;
        hit_rt = m.dest == bus.rt_in;
        chk({tag, ".valid"}, 32'(bus.valid_out), 32'(m.v));
        chk({tag, ".ctrl"}, 32'({bus.RegWrite_out, bus.MemtoReg_out, bus.MemRead_out, bus.MemWrite_out}), 32'(m.ctrl));
        chk({tag, ".alu"}, bus.ALU_Result_out, m.alu);
        chk({tag, ".rtd"}, bus.RT_data_out, m.rtd);
        chk({tag, ".dest"}, 32'(bus.dest_out), 32'(m.dest));
        chk({tag, ".fwd_rs"}, 32'(bus.fwd_rs_hit), 32'(live && hit_rs));
        chk({tag, ".fwd_rt"}, 32'(bus.fwd_rt_hit), 32'(live && hit_rt));
        chk({tag, ".load_use"}, 32'(bus.load_use_hazard),
            32'(m.v && m.ctrl[1] && m.dest != 0 && (hit_rs || hit_rt)));
        chk_cnt();
    endtask

    initial begin
        m = '{default: '0};
        m_bub = 0;
        m_stl = 0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Control nibble order: {RegWrite, MemtoReg, MemRead, MemWrite}.
        tbl.push_back(mk(0,1,1,1,4'hF,32'hFFFFFFFF,32'hFFFFFFFF,31,31,31, 0,4'h0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,1,4'hF,32'hFFFFFFFF,32'hFFFFFFFF,31,31,31, 0,4'h0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,1,4'h8,32'h9,32'h3,8,8,9,             1,4'h8,32'h9,32'h3,8,1,0,0));
        tbl.push_back(mk(1,0,0,0,4'hF,32'h5,32'h6,7,7,7,             0,4'h0,32'h5,32'h6,7,0,0,0));
        tbl.push_back(mk(1,0,0,1,4'h8,32'h1,32'h2,0,0,0,             1,4'h8,32'h1,32'h2,0,0,0,0));
        tbl.push_back(mk(1,0,0,1,4'hE,32'h40,32'h44,5,3,5,           1,4'hE,32'h40,32'h44,5,0,1,1));
        tbl.push_back(mk(1,1,1,1,4'hF,32'hAA,32'hBB,6,5,5,           0,4'h0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,1,4'h8,32'h11,32'h0,4,4,0,            1,4'h8,32'h11,32'h0,4,1,0,0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1,1,0,1,4'h8,32'h22,32'h0,4,4,0,        1,4'h8,32'h11,32'h0,4,1,0,0));
        tbl.push_back(mk(1,0,0,1,4'h8,32'h22,32'h0,4,4,0,            1,4'h8,32'h22,32'h0,4,1,0,0));
        tbl.push_back(mk(1,0,0,1,4'h1,32'h30,32'h31,9,9,9,           1,4'h1,32'h30,32'h31,9,0,0,0));

        @(negedge clk);
        foreach (tbl[i]) begin
            drv(tbl[i].rst_n, tbl[i].stall, tbl[i].flush, tbl[i].v, tbl[i].ctrl,
                tbl[i].alu, tbl[i].rtd, tbl[i].dest, tbl[i].rs, tbl[i].rt);
            tick();
            chk($sformatf("v%0d.valid", i), 32'(bus.valid_out), 32'(tbl[i].e_v));
            chk($sformatf("v%0d.ctrl", i),
                32'({bus.RegWrite_out, bus.MemtoReg_out, bus.MemRead_out, bus.MemWrite_out}), 32'(tbl[i].e_ctrl));
            chk($sformatf("v%0d.alu", i), bus.ALU_Result_out, tbl[i].e_alu);
            chk($sformatf("v%0d.rtd", i), bus.RT_data_out, tbl[i].e_rtd);
            chk($sformatf("v%0d.dest", i), 32'(bus.dest_out), 32'(tbl[i].e_dest));
            chk($sformatf("v%0d.fwd_rs", i), 32'(bus.fwd_rs_hit), 32'(tbl[i].e_rs));
            chk($sformatf("v%0d.fwd_rt", i), 32'(bus.fwd_rt_hit), 32'(tbl[i].e_rt));
            chk($sformatf("v%0d.load_use", i), 32'(bus.load_use_hazard), 32'(tbl[i].e_lu));
            chk_cnt();
        end

        // A reset pulse that ends before the edge must not clear the held store.
        drv(1, 1, 0, 0, 4'h0, 32'h0, 32'h0, 0, 9, 9);
        @(negedge clk);
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        chk("async_rst.valid", 32'(bus.valid_out), 32'd1);
        chk("async_rst.dest", 32'(bus.dest_out), 32'd9);

        // Load-use flag must persist while the load is held by a stall.
        drv(1, 0, 0, 1, 4'hE, 32'h100, 32'h0, 12, 12, 1);
        tick();
        drv(1, 1, 0, 1, 4'h0, 32'h0, 32'h0, 0, 1, 12);
        tick();
        chk("stall_lu.load_use", 32'(bus.load_use_hazard), 32'd1);
        chk("stall_lu.fwd_rt", 32'(bus.fwd_rt_hit), 32'd1);

`ifdef EX_MEM_PERF_CNT_EN
        drv(0, 0, 0, 1, 4'h0, 32'h0, 32'h0, 0, 0, 0);
        tick();
        drv(1, 1, 0, 1, 4'h0, 32'h0, 32'h0, 0, 0, 0);
        repeat (5) tick();
        chk("stall_sat", 32'(stall_cnt), 32'd3);
        chk("bubble_idle", 32'(bubble_cnt), 32'd0);
        drv(1, 0, 1, 1, 4'h0, 32'h0, 32'h0, 0, 0, 0);
        repeat (4) tick();
        chk("bubble_sat", 32'(bubble_cnt), 32'd3);
`endif

        for (int i = 0; i < 400; i++) begin
            drv(($urandom % 40) != 0, ($urandom % 4) == 0, ($urandom % 10) == 0,
                ($urandom % 4) != 0, 4'($urandom), $urandom, $urandom,
                5'($urandom % 8), 5'($urandom % 8), 5'($urandom % 8));
            tick();
            chk_model($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
